ppu_pixel_mux: RTL and testbench

//  Final pixel stage of the PPU, directly downstream of the background and sprite sub-blocks.
//  - Each pixel clock, resolves bg vs sprite priority into a 5-bit palette RAM address.
//  - Looks up the 6-bit NES system colour and registers it for the video output block.
//  - Owns the 32x6 palette RAM used for CPU 0x3F00-0x3F1F accesses through 0x2007.
//  - Detects sprite-0 hit for status bit 0x2002.6.
//

---
 rtl/ppu_pixel_mux_pkg.sv | 39 +++
 rtl/ppu_pixel_mux_pal_ram.sv | 42 ++++
 rtl/ppu_pixel_mux.sv | 95 +++++++++
 tb/tb_ppu_pixel_mux.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pixel_mux_pkg.sv
// Shared definitions for the PPU pixel mux: visible area, palette mirroring, priority select.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package ppu_pixel_mux_pkg;

  localparam int VIS_W_DEF = 256;
  localparam int VIS_H_DEF = 240;

  // Clearing bit 4 folds the sprite backdrop slots 0x10/14/18/1C onto 0x00/04/08/0C.
  localparam logic [4:0] PAL_MIRROR_MASK = 5'h0F;
  localparam logic [4:0] BACKDROP_ADDR   = 5'h00;

  // Per-pixel inputs from the background and sprite pipelines.
  typedef struct packed {
    logic [3:0] bg;
    logic [3:0] spr;
    logic       spr_priority;
  } pix_src_t;

  // Apply the palette address aliasing shared by the CPU and render paths.
  function automatic logic [4:0] pal_mirror(input logic [4:0] a);
    return (a[1:0] == 2'b00) ? (a & PAL_MIRROR_MASK) : a;
  endfunction

  // Resolve background vs sprite into a palette RAM address.
  function automatic logic [4:0] pix_priority(input pix_src_t p);
    logic bg_o;
    logic sp_o;
    bg_o = |p.bg[1:0];
    sp_o = |p.spr[1:0];
    if (!bg_o && !sp_o)
      return BACKDROP_ADDR;
    else if (sp_o && (!bg_o || !p.spr_priority))
      return {1'b1, p.spr};
    else
      return {1'b0, p.bg};
  endfunction

endpackage

// File: rtl/ppu_pixel_mux_pal_ram.sv
// 32x6 palette RAM: one write port, async CPU read port and async render read port.
// Latency: writes land on the clock edge; reads are combinational (old data in the write cycle).
// Backpressure: none; every write strobe is accepted.
module ppu_pixel_mux_pal_ram
  import ppu_pixel_mux_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       wr_en_in,
  input  logic [4:0] wr_a_in,
  input  logic [5:0] wr_d_in,
  input  logic [4:0] ri_a_in,
  output logic [5:0] ri_d_out,
  input  logic [4:0] rd_a_in,
  output logic [5:0] rd_d_out
);

  logic [5:0] pal_q [32];
  logic [4:0] wr_a_m;
  logic [4:0] ri_a_m;
  logic [4:0] rd_a_m;

  // Mirrored address decode; render lookups of any transparent slot use the backdrop.
  always_comb begin
    wr_a_m = pal_mirror(wr_a_in);
    ri_a_m = pal_mirror(ri_a_in);
    rd_a_m = (rd_a_in[1:0] == 2'b00) ? BACKDROP_ADDR : rd_a_in;
  end

  // Palette storage; reset clears every entry.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < 32; i++) pal_q[i] <= 6'h00;
    end else if (wr_en_in) begin
      pal_q[wr_a_m] <= wr_d_in;
    end
  end

  assign ri_d_out = pal_q[ri_a_m];
  assign rd_d_out = pal_q[rd_a_m];

endmodule

// File: rtl/ppu_pixel_mux.sv
// PPU final pixel stage: bg/sprite priority, palette lookup, sprite-0 hit; optional PPU_GREYSCALE_EN.
// Latency: colour registered one clock after pix_pulse_in; pal_d_out combinational.
// Backpressure: none; the pixel stream and CPU accesses are never stalled.
module ppu_pixel_mux
  import ppu_pixel_mux_pkg::*;
#(
  parameter int VIS_W = VIS_W_DEF,
  parameter int VIS_H = VIS_H_DEF
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [9:0] nes_x_in,
  input  logic [9:0] nes_y_in,
  input  logic       pix_pulse_in,
  input  logic [3:0] bg_palette_idx_in,
  input  logic [3:0] spr_palette_idx_in,
  input  logic       spr_priority_in,
  input  logic       spr_primary_in,
  input  logic       bg_en_in,
  input  logic       spr_en_in,
  input  logic       spr0_hit_clr_in,
  input  logic       greyscale_in,
  input  logic [4:0] pal_a_in,
  input  logic [5:0] pal_d_in,
  input  logic       pal_wr_in,
  output logic [5:0] pal_d_out,
  output logic [5:0] sys_palette_idx_out,
  output logic       spr0_hit_out
);

  pix_src_t   pix_src;
  logic [4:0] sel;
  logic [4:0] rd_a;
  logic [5:0] rd_d;
  logic [5:0] colour_nxt;
  logic       visible;
  logic       hit_set;

  // Priority select, visibility and sprite-0 hit detection.
  always_comb begin
    pix_src.bg           = bg_palette_idx_in;
    pix_src.spr          = spr_palette_idx_in;
    pix_src.spr_priority = spr_priority_in;
    sel     = pix_priority(pix_src);
    visible = (nes_x_in < 10'(VIS_W)) && (nes_y_in < 10'(VIS_H));
    rd_a    = visible ? sel : BACKDROP_ADDR;
    // The hit ignores sprite priority and is never reported in the last column.
    hit_set = pix_pulse_in && bg_en_in && spr_en_in && spr_primary_in &&
              (|bg_palette_idx_in[1:0]) && (|spr_palette_idx_in[1:0]) &&
              (nes_x_in < 10'd255) && (nes_y_in < 10'(VIS_H));
  end

  ppu_pixel_mux_pal_ram u_pal_ram (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .wr_en_in (pal_wr_in),
    .wr_a_in  (pal_a_in),
    .wr_d_in  (pal_d_in),
    .ri_a_in  (pal_a_in),
    .ri_d_out (pal_d_out),
    .rd_a_in  (rd_a),
    .rd_d_out (rd_d)
  );

`ifdef PPU_GREYSCALE_EN
  // Greyscale keeps only the luma bits of the system colour.
  always_comb begin
    colour_nxt = greyscale_in ? (rd_d & 6'h30) : rd_d;
  end
`else
  logic unused_greyscale;
  // Greyscale is not built in; the colour passes through untouched.
  always_comb begin
    unused_greyscale = greyscale_in;
    colour_nxt       = rd_d;
  end
`endif

  // Output colour register, advanced only on the pixel pulse.
  always_ff @(posedge clk_in) begin
    if (rst_in)
      sys_palette_idx_out <= 6'h00;
    else if (pix_pulse_in)
      sys_palette_idx_out <= colour_nxt;
  end

  // Sticky sprite-0 hit flag; clear wins over a simultaneous set.
  always_ff @(posedge clk_in) begin
    if (rst_in || spr0_hit_clr_in)
      spr0_hit_out <= 1'b0;
    else if (hit_set)
      spr0_hit_out <= 1'b1;
  end

endmodule

// File: tb/tb_ppu_pixel_mux.sv
// Directed bench for ppu_pixel_mux: vector table for priority/lookup, hand sequences for hit and write timing.
// Latency: checks the colour one clock after each pixel pulse.
// Backpressure: not applicable.
module tb_ppu_pixel_mux;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [9:0] nes_x_in;
  logic [9:0] nes_y_in;
  logic       pix_pulse_in;
  logic [3:0] bg_palette_idx_in;
  logic [3:0] spr_palette_idx_in;
  logic       spr_priority_in;
  logic       spr_primary_in;
  logic       bg_en_in;
  logic       spr_en_in;
  logic       spr0_hit_clr_in;
  logic       greyscale_in;
  logic [4:0] pal_a_in;
  logic [5:0] pal_d_in;
  logic       pal_wr_in;
  logic [5:0] pal_d_out;
  logic [5:0] sys_palette_idx_out;
  logic       spr0_hit_out;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [3:0] bg;
    logic [3:0] spr;
    logic       prio;
    logic [9:0] x;
    logic [9:0] y;
    logic [5:0] exp_out;
  } vec_t;

  vec_t vecs [10];

  ppu_pixel_mux dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .nes_x_in            (nes_x_in),
    .nes_y_in            (nes_y_in),
    .pix_pulse_in        (pix_pulse_in),
    .bg_palette_idx_in   (bg_palette_idx_in),
    .spr_palette_idx_in  (spr_palette_idx_in),
    .spr_priority_in     (spr_priority_in),
    .spr_primary_in      (spr_primary_in),
    .bg_en_in            (bg_en_in),
    .spr_en_in           (spr_en_in),
    .spr0_hit_clr_in     (spr0_hit_clr_in),
    .greyscale_in        (greyscale_in),
    .pal_a_in            (pal_a_in),
    .pal_d_in            (pal_d_in),
    .pal_wr_in           (pal_wr_in),
    .pal_d_out           (pal_d_out),
    .sys_palette_idx_out (sys_palette_idx_out),
    .spr0_hit_out        (spr0_hit_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
  endtask

  task automatic pal_write(input logic [4:0] a, input logic [5:0] d);
    pal_a_in  = a;
    pal_d_in  = d;
    pal_wr_in = 1'b1;
    tick();
    pal_wr_in = 1'b0;
  endtask

  task automatic set_pix(input logic [3:0] bg, input logic [3:0] spr, input logic prio,
                         input logic [9:0] x, input logic [9:0] y);
    bg_palette_idx_in  = bg;
    spr_palette_idx_in = spr;
    spr_priority_in    = prio;
    nes_x_in           = x;
    nes_y_in           = y;
  endtask

  task automatic pulse();
    pix_pulse_in = 1'b1;
    tick();
    pix_pulse_in = 1'b0;
  endtask

  initial begin
    logic [5:0] grey_exp;
    // Palette used below: 00=0F 05=16 19=2A 0A=07 13=33
    vecs[0] = '{4'h5, 4'h0, 1'b0, 10'd10,  10'd10,  6'h16}; // bg only
    vecs[1] = '{4'h5, 4'h9, 1'b0, 10'd10,  10'd10,  6'h2A}; // sprite in front
    vecs[2] = '{4'h5, 4'h9, 1'b1, 10'd10,  10'd10,  6'h16}; // sprite behind bg
    vecs[3] = '{4'h0, 4'h0, 1'b0, 10'd20,  10'd30,  6'h0F}; // backdrop
    vecs[4] = '{4'h0, 4'h3, 1'b1, 10'd20,  10'd30,  6'h33}; // behind but bg transparent
    vecs[5] = '{4'h4, 4'h8, 1'b0, 10'd1,   10'd1,   6'h0F}; // both transparent, high bits set
    vecs[6] = '{4'h5, 4'h0, 1'b0, 10'd300, 10'd10,  6'h0F}; // right of visible area
    vecs[7] = '{4'h5, 4'h0, 1'b0, 10'd10,  10'd240, 6'h0F}; // below visible area
    vecs[8] = '{4'hA, 4'h0, 1'b0, 10'd255, 10'd239, 6'h07}; // last visible pixel
    vecs[9] = '{4'h5, 4'h8, 1'b0, 10'd100, 10'd100, 6'h16}; // sprite transparent

    rst_in = 1'b1; pix_pulse_in = 1'b0; spr_primary_in = 1'b0;
    bg_en_in = 1'b1; spr_en_in = 1'b1; spr0_hit_clr_in = 1'b0; greyscale_in = 1'b0;
    pal_a_in = 5'h00; pal_d_in = 6'h00; pal_wr_in = 1'b0;
    set_pix(4'h0, 4'h0, 1'b0, 10'd0, 10'd0);
    tick(); tick();
    check("reset_out", 8'(sys_palette_idx_out), 8'h00);
    check("reset_hit", 8'(spr0_hit_out), 8'h00);
    pal_a_in = 5'h1F;
    #1 check("reset_pal_1f", 8'(pal_d_out), 8'h00);
    rst_in = 1'b0;
    tick();

    pal_write(5'h00, 6'h0F);
    pal_write(5'h05, 6'h16);
    pal_write(5'h19, 6'h2A);
    pal_write(5'h0A, 6'h07);
    pal_write(5'h13, 6'h33);
    pal_a_in = 5'h05;
    #1 check("ri_read_05", 8'(pal_d_out), 8'h16);

    for (int i = 0; i < 10; i++) begin
      set_pix(vecs[i].bg, vecs[i].spr, vecs[i].prio, vecs[i].x, vecs[i].y);
      pulse();
      check($sformatf("vec%0d_out", i), 8'(sys_palette_idx_out), 8'(vecs[i].exp_out));
    end
    check("vec_no_hit", 8'(spr0_hit_out), 8'h00);

    // Output holds between pulses.
    set_pix(4'h5, 4'h9, 1'b0, 10'd50, 10'd50);
    tick(); tick();
    check("hold_no_pulse", 8'(sys_palette_idx_out), 8'h16);

    // Mirrored write 0x10 -> 0x00.
    pal_write(5'h10, 6'h21);
    pal_a_in = 5'h00;
    #1 check("mirror_read_00", 8'(pal_d_out), 8'h21);
    pal_a_in = 5'h10;
    #1 check("mirror_read_10", 8'(pal_d_out), 8'h21);
    set_pix(4'h0, 4'h0, 1'b0, 10'd50, 10'd50);
    pulse();
    check("mirror_backdrop", 8'(sys_palette_idx_out), 8'h21);

    // Sprite-0 hit.
    spr_primary_in = 1'b1;
    set_pix(4'h5, 4'h9, 1'b0, 10'd255, 10'd10);
    pulse();
    check("hit_x255", 8'(spr0_hit_out), 8'h00);
    set_pix(4'h5, 4'h9, 1'b0, 10'd10, 10'd240);
    pulse();
    check("hit_y240", 8'(spr0_hit_out), 8'h00);
    bg_en_in = 1'b0;
    set_pix(4'h5, 4'h9, 1'b0, 10'd100, 10'd10);
    pulse();
    check("hit_bg_off", 8'(spr0_hit_out), 8'h00);
    bg_en_in = 1'b1;
    set_pix(4'h5, 4'h9, 1'b0, 10'd254, 10'd10);
    tick();
    check("hit_needs_pulse", 8'(spr0_hit_out), 8'h00);
    pulse();
    check("hit_x254", 8'(spr0_hit_out), 8'h01);
    spr_primary_in = 1'b0;
    pulse();
    check("hit_sticky", 8'(spr0_hit_out), 8'h01);
    spr0_hit_clr_in = 1'b1;
    tick();
    spr0_hit_clr_in = 1'b0;
    check("hit_clear", 8'(spr0_hit_out), 8'h00);
    spr_primary_in = 1'b1;
    spr0_hit_clr_in = 1'b1;
    pulse();
    spr0_hit_clr_in = 1'b0;
    check("hit_clr_wins", 8'(spr0_hit_out), 8'h00);
    set_pix(4'h5, 4'h9, 1'b1, 10'd100, 10'd10);
    pulse();
    check("hit_prio_ignored", 8'(spr0_hit_out), 8'h01);
    spr_primary_in = 1'b0;

    // Write during the lookup cycle: old colour is registered.
    set_pix(4'h5, 4'h0, 1'b0, 10'd60, 10'd60);
    pal_a_in = 5'h05; pal_d_in = 6'h3D; pal_wr_in = 1'b1; pix_pulse_in = 1'b1;
    tick();
    pal_wr_in = 1'b0; pix_pulse_in = 1'b0;
    check("wr_same_cycle_old", 8'(sys_palette_idx_out), 8'h16);
    check("wr_ri_new", 8'(pal_d_out), 8'h3D);
    pulse();
    check("wr_next_pulse_new", 8'(sys_palette_idx_out), 8'h3D);

    // Greyscale on a 0x2A entry.
`ifdef PPU_GREYSCALE_EN
    grey_exp = 6'h20;
`else
    grey_exp = 6'h2A;
`endif
    greyscale_in = 1'b1;
    set_pix(4'h5, 4'h9, 1'b0, 10'd70, 10'd70);
    pulse();
    check("greyscale_out", 8'(sys_palette_idx_out), 8'(grey_exp));
    pal_a_in = 5'h19;
    #1 check("greyscale_ri", 8'(pal_d_out), 8'h2A);
    greyscale_in = 1'b0;

    // Reset mid-frame wipes everything.
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check("rst_mid_hit", 8'(spr0_hit_out), 8'h00);
    check("rst_mid_out", 8'(sys_palette_idx_out), 8'h00);
    check("rst_mid_pal", 8'(pal_d_out), 8'h00);
    set_pix(4'h5, 4'h9, 1'b0, 10'd80, 10'd80);
    pulse();
    check("rst_mid_lookup", 8'(sys_palette_idx_out), 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
